neuron_train_feeder: RTL and testbench

Upstream training sequencer for the neuron wrapper. It stores a small table of binary input samples and their expected outputs, and replays that table to the neuron in learning mode, one epoch at a time. Each returned result is compared with the expected bit, and errors are counted per epoch. Training stops on the first error-free epoch or after a maximum epoch count; the block then releases the neuron to working mode and reports status.

---
 rtl/neuron_train_feeder.sv | 229 ++++++++++++++++++++++
 tb/tb_neuron_train_feeder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_train_feeder.sv
// neuron_train_feeder
// Training sequencer for the neuron wrapper. It holds a small table of binary
// samples and their expected outputs, and replays that table to the neuron in
// learning mode one epoch at a time. It counts the errors in each epoch and
// stops on the first error-free epoch or after MAX_EPOCHS epochs, then puts the
// neuron back in working mode.
//
// Optional feature: define NEURON_FEEDER_ROTATE_EN to make epoch e start at
// sample (e mod SAMPLES_NUM) and wrap around. Without it, every epoch walks
// the table from 0 to SAMPLES_NUM-1.
module neuron_train_feeder #(
  parameter int INPUTS_NUM  = 3,
  parameter int SAMPLES_NUM = 8,
  parameter int MAX_EPOCHS  = 255,
  parameter int EPOCH_W     = $clog2(MAX_EPOCHS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             smp_wr_en,
  input  logic [$clog2(SAMPLES_NUM)-1:0]   smp_wr_addr,
  input  logic [INPUTS_NUM-1:0]            smp_wr_data,
  input  logic                             smp_wr_exp,
  input  logic                             start,
  output logic                             mode,
  output logic                             in_data_vld,
  output logic                             in_data [INPUTS_NUM-1:0],
  input  logic                             in_data_rdy,
  output logic                             expected_result_data,
  input  logic                             result_data,
  input  logic                             result_vld,
  output logic                             busy,
  output logic                             done,
  output logic                             converged,
  output logic [EPOCH_W-1:0]               epoch_cnt,
  output logic [$clog2(SAMPLES_NUM+1)-1:0] err_cnt
);

  localparam int ADDR_W = $clog2(SAMPLES_NUM);
  localparam int ERR_W  = $clog2(SAMPLES_NUM + 1);

  localparam logic [ADDR_W-1:0]  LAST_IDX    = ADDR_W'(SAMPLES_NUM - 1);
  localparam logic [ADDR_W:0]    SAMPLES_EXT = (ADDR_W + 1)'(SAMPLES_NUM);
  localparam logic [EPOCH_W-1:0] MAX_EPOCH_V = EPOCH_W'(MAX_EPOCHS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_WAIT_RES,
    S_EPOCH_END,
    S_DONE
  } state_t;

  // Sample table: input bits and the expected neuron output for each sample.
  logic [INPUTS_NUM-1:0] smp_mem [SAMPLES_NUM];
  logic                  exp_mem [SAMPLES_NUM];

  state_t                state_q;
  logic [ADDR_W-1:0]     idx_q;
  logic [ERR_W-1:0]      err_q;
  logic [EPOCH_W-1:0]    epoch_q;
  logic                  done_q;
  logic                  conv_q;
  logic                  mode_q;
  logic                  busy_q;
  logic                  vld_q;
  logic [INPUTS_NUM-1:0] data_q;
  logic                  exp_q;

  logic [ADDR_W-1:0]     nxt_idx;
  logic [ADDR_W-1:0]     epoch_first_idx;
  logic                  last_smp;
  logic                  wr_ok;

`ifdef NEURON_FEEDER_ROTATE_EN
  // First index of the running epoch and number of results already taken.
  logic [ADDR_W-1:0]     first_q;
  logic [ADDR_W-1:0]     res_cnt_q;
`endif

  // Index arithmetic: the table is walked upward and wraps after the last entry.
  always_comb begin
    nxt_idx = (idx_q == LAST_IDX) ? '0 : idx_q + ADDR_W'(1);
`ifdef NEURON_FEEDER_ROTATE_EN
    // Each new epoch starts one entry later than the previous one.
    epoch_first_idx = (first_q == LAST_IDX) ? '0 : first_q + ADDR_W'(1);
    // The epoch ends after SAMPLES_NUM results, whatever index it started at.
    last_smp        = (res_cnt_q == LAST_IDX);
`else
    epoch_first_idx = '0;
    last_smp        = (idx_q == LAST_IDX);
`endif
  end

  // Table writes are taken only while idle and only for in-range addresses.
  assign wr_ok = smp_wr_en && !busy_q && ({1'b0, smp_wr_addr} < SAMPLES_EXT);

  // Sample table storage.
  // NOTE: the table has no reset on purpose: its contents must survive rst,
  // and leaving it out of reset lets the tools map it onto plain storage.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      smp_mem[smp_wr_addr] <= smp_wr_data;
      exp_mem[smp_wr_addr] <= smp_wr_exp;
    end
  end

  // Training state machine: sequences epochs and registers every output.
  // NOTE: all state here is written with <= so every branch sees the values
  // from before the clock edge, just as the flops do.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      err_q     <= '0;
      epoch_q   <= '0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      vld_q     <= 1'b0;
      data_q    <= '0;
      exp_q     <= 1'b0;
`ifdef NEURON_FEEDER_ROTATE_EN
      first_q   <= '0;
      res_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_PRESENT;
            idx_q     <= '0;
            err_q     <= '0;
            epoch_q   <= '0;
            done_q    <= 1'b0;
            conv_q    <= 1'b0;
            mode_q    <= 1'b1;
            busy_q    <= 1'b1;
            vld_q     <= 1'b1;
            data_q    <= smp_mem[0];
            exp_q     <= exp_mem[0];
`ifdef NEURON_FEEDER_ROTATE_EN
            first_q   <= '0;
            res_cnt_q <= '0;
`endif
          end
        end

        S_PRESENT: begin
          // Sample and expected bit stay put until the neuron accepts them.
          if (vld_q && in_data_rdy) begin
            vld_q   <= 1'b0;
            state_q <= S_WAIT_RES;
          end
        end

        S_WAIT_RES: begin
          if (result_vld) begin
            if (result_data != exp_q) begin
              err_q <= err_q + ERR_W'(1);
            end
            if (last_smp) begin
              state_q <= S_EPOCH_END;
            end else begin
              idx_q     <= nxt_idx;
              state_q   <= S_PRESENT;
              vld_q     <= 1'b1;
              data_q    <= smp_mem[nxt_idx];
              exp_q     <= exp_mem[nxt_idx];
`ifdef NEURON_FEEDER_ROTATE_EN
              res_cnt_q <= res_cnt_q + ADDR_W'(1);
`endif
            end
          end
        end

        S_EPOCH_END: begin
          epoch_q <= epoch_q + EPOCH_W'(1);
          if (err_q == '0) begin
            state_q <= S_DONE;
            conv_q  <= 1'b1;
            done_q  <= 1'b1;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if ((epoch_q + EPOCH_W'(1)) == MAX_EPOCH_V) begin
            state_q <= S_DONE;
            conv_q  <= 1'b0;
            done_q  <= 1'b1;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= S_PRESENT;
            err_q     <= '0;
            idx_q     <= epoch_first_idx;
            vld_q     <= 1'b1;
            data_q    <= smp_mem[epoch_first_idx];
            exp_q     <= exp_mem[epoch_first_idx];
`ifdef NEURON_FEEDER_ROTATE_EN
            first_q   <= epoch_first_idx;
            res_cnt_q <= '0;
`endif
          end
        end

        default: begin
          state_q <= S_IDLE;
          mode_q  <= 1'b0;
          busy_q  <= 1'b0;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  // Output mapping; every output comes straight from a register.
  assign mode                 = mode_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign converged            = conv_q;
  assign in_data_vld          = vld_q;
  assign expected_result_data = exp_q;
  assign epoch_cnt            = epoch_q;
  assign err_cnt              = err_q;

  for (genvar i = 0; i < INPUTS_NUM; i++) begin : g_in_data
    assign in_data[i] = data_q[i];
  end

endmodule

// File: tb/tb_neuron_train_feeder.sv
// Self-checking bench for neuron_train_feeder (INPUTS_NUM=2, SAMPLES_NUM=4,
// MAX_EPOCHS=4). A behavioural neuron plus a training-rule model decides which
// sample must be presented, how many errors each epoch has and when training ends.
module tb_neuron_train_feeder;

  localparam int INP  = 2;
  localparam int N    = 4;
  localparam int MAXE = 4;
  localparam int EW   = $clog2(MAXE + 1);
  localparam int AW   = $clog2(N);
  localparam int CW   = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          smp_wr_en;
  logic [AW-1:0] smp_wr_addr;
  logic [INP-1:0] smp_wr_data;
  logic          smp_wr_exp;
  logic          start;
  logic          mode;
  logic          in_data_vld;
  logic          in_data [INP-1:0];
  logic          in_data_rdy;
  logic          expected_result_data;
  logic          result_data;
  logic          result_vld;
  logic          busy;
  logic          done;
  logic          converged;
  logic [EW-1:0] epoch_cnt;
  logic [CW-1:0] err_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference copy of the sample table.
  logic [INP-1:0] tb_tbl [N];
  logic           tb_exp [N];

  always #5 clk = ~clk;

  neuron_train_feeder #(
    .INPUTS_NUM (INP),
    .SAMPLES_NUM(N),
    .MAX_EPOCHS (MAXE)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .smp_wr_en           (smp_wr_en),
    .smp_wr_addr         (smp_wr_addr),
    .smp_wr_data         (smp_wr_data),
    .smp_wr_exp          (smp_wr_exp),
    .start               (start),
    .mode                (mode),
    .in_data_vld         (in_data_vld),
    .in_data             (in_data),
    .in_data_rdy         (in_data_rdy),
    .expected_result_data(expected_result_data),
    .result_data         (result_data),
    .result_vld          (result_vld),
    .busy                (busy),
    .done                (done),
    .converged           (converged),
    .epoch_cnt           (epoch_cnt),
    .err_cnt             (err_cnt)
  );

  function automatic logic [INP-1:0] pack_in();
    logic [INP-1:0] v;
    for (int i = 0; i < INP; i++) v[i] = in_data[i];
    return v;
  endfunction

  // Which table entry sample k of epoch e must be.
  function automatic int model_idx(input int e, input int k);
`ifdef NEURON_FEEDER_ROTATE_EN
    return (e + k) % N;
`else
    return k;
`endif
  endfunction

  // kind 0: AND table, kind 1: random contents.
  task automatic load_table(input int kind);
    for (int a = 0; a < N; a++) begin
      @(negedge clk);
      smp_wr_en   = 1'b1;
      smp_wr_addr = AW'(a);
      smp_wr_data = (kind == 0) ? INP'(a) : INP'($urandom_range(0, (1 << INP) - 1));
      smp_wr_exp  = (kind == 0) ? (a == N - 1) : 1'($urandom_range(0, 1));
      tb_tbl[a]   = smp_wr_data;
      tb_exp[a]   = smp_wr_exp;
    end
    @(negedge clk);
    smp_wr_en = 1'b0;
  endtask

  // Runs one training session against the model.
  // wrong_kind 0: neuron answers 0 for every sample in the first wrong_epochs epochs
  // wrong_kind 1: neuron inverts every answer in the first wrong_epochs epochs
  // wrong_kind 2: neuron inverts answers at random in the first wrong_epochs epochs
  // disturb_epoch: on sample 1 of that epoch, issue start, a table write and a stray result
  // abort_epoch: assert rst while waiting for the first result of that epoch
  task automatic drive_training(input int wrong_epochs, input int wrong_kind,
                                input int stall_min, input int stall_max,
                                input int disturb_epoch, input int abort_epoch,
                                output int n_xfer);
    int e, k, errs, idx, stall, lat;
    bit finished, wrong;
    logic [INP-1:0] held_d;
    logic held_e;
    e = 0; k = 0; errs = 0; n_xfer = 0; finished = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!finished) begin
      idx = model_idx(e, k);
      n_total++;
      if (in_data_vld !== 1'b1 || mode !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL present_state e%0d k%0d: vld=%b mode=%b busy=%b done=%b want 1 1 1 0",
                 e, k, in_data_vld, mode, busy, done);
      else n_pass++;
      n_total++;
      if (pack_in() !== tb_tbl[idx] || expected_result_data !== tb_exp[idx] || err_cnt !== CW'(errs))
        $display("FAIL present_sample e%0d k%0d: data=%b exp=%b err=%0d want data=%b exp=%b err=%0d",
                 e, k, pack_in(), expected_result_data, err_cnt, tb_tbl[idx], tb_exp[idx], errs);
      else n_pass++;
      held_d = pack_in();
      held_e = expected_result_data;

      if (e == disturb_epoch && k == 1) begin
        start       = 1'b1;
        smp_wr_en   = 1'b1;
        smp_wr_addr = AW'(idx);
        smp_wr_data = ~tb_tbl[idx];
        smp_wr_exp  = ~tb_exp[idx];
        result_vld  = 1'b1;
        result_data = ~tb_exp[idx];
        @(negedge clk);
        start = 1'b0; smp_wr_en = 1'b0; result_vld = 1'b0;
        n_total++;
        if (in_data_vld !== 1'b1 || pack_in() !== held_d || err_cnt !== CW'(errs) || epoch_cnt !== EW'(e))
          $display("FAIL ignored_inputs: vld=%b data=%b err=%0d epoch=%0d want 1 %b %0d %0d",
                   in_data_vld, pack_in(), err_cnt, epoch_cnt, held_d, errs, e);
        else n_pass++;
      end

      stall = $urandom_range(stall_min, stall_max);
      repeat (stall) begin
        @(negedge clk);
        n_total++;
        if (in_data_vld !== 1'b1 || pack_in() !== held_d || expected_result_data !== held_e)
          $display("FAIL stall_hold: vld=%b data=%b exp=%b want 1 %b %b",
                   in_data_vld, pack_in(), expected_result_data, held_d, held_e);
        else n_pass++;
      end
      in_data_rdy = 1'b1;
      @(negedge clk);
      in_data_rdy = 1'b0;
      n_xfer++;
      n_total++;
      if (in_data_vld !== 1'b0 || mode !== 1'b1)
        $display("FAIL vld_drop: vld=%b mode=%b want 0 1", in_data_vld, mode);
      else n_pass++;

      if (e == abort_epoch) begin
        rst = 1'b1;
        #1;
        n_total++;
        if (mode !== 1'b0 || in_data_vld !== 1'b0 || pack_in() !== '0 || expected_result_data !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0 || epoch_cnt !== '0 || err_cnt !== '0)
          $display("FAIL abort_reset: mode=%b vld=%b data=%b exp=%b busy=%b done=%b conv=%b epoch=%0d err=%0d want all 0",
                   mode, in_data_vld, pack_in(), expected_result_data, busy, done, converged, epoch_cnt, err_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        return;
      end

      lat = $urandom_range(0, 3);
      repeat (lat) @(negedge clk);
      wrong = (e < wrong_epochs) &&
              ((wrong_kind == 0 && tb_exp[idx] == 1'b1) || wrong_kind == 1 ||
               (wrong_kind == 2 && $urandom_range(0, 1) == 1));
      result_vld  = 1'b1;
      result_data = wrong ? ~tb_exp[idx] : tb_exp[idx];
      @(negedge clk);
      result_vld = 1'b0;
      if (wrong) errs++;
      k++;

      if (k == N) begin
        n_total++;
        if (in_data_vld !== 1'b0 || mode !== 1'b1 || err_cnt !== CW'(errs))
          $display("FAIL epoch_end e%0d: vld=%b mode=%b err=%0d want 0 1 %0d",
                   e, in_data_vld, mode, err_cnt, errs);
        else n_pass++;
        @(negedge clk);
        e++;
        n_total++;
        if (epoch_cnt !== EW'(e))
          $display("FAIL epoch_cnt: got %0d want %0d", epoch_cnt, e);
        else n_pass++;
        if (errs == 0 || e == MAXE) begin
          finished = 1;
          n_total++;
          if (done !== 1'b1 || converged !== (errs == 0) || err_cnt !== CW'(errs) ||
              mode !== 1'b0 || busy !== 1'b0 || in_data_vld !== 1'b0)
            $display("FAIL final_status: done=%b conv=%b err=%0d mode=%b busy=%b vld=%b want 1 %b %0d 0 0 0",
                     done, converged, err_cnt, mode, busy, in_data_vld, errs == 0, errs);
          else n_pass++;
        end else begin
          n_total++;
          if (err_cnt !== '0 || done !== 1'b0)
            $display("FAIL new_epoch: err=%0d done=%b want 0 0", err_cnt, done);
          else n_pass++;
          errs = 0;
          k    = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++;
    if (mode !== 1'b0 || in_data_vld !== 1'b0 || pack_in() !== '0 || expected_result_data !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || converged !== 1'b0 || epoch_cnt !== '0 || err_cnt !== '0)
      $display("FAIL reset_values: mode=%b vld=%b data=%b busy=%b done=%b conv=%b epoch=%0d err=%0d want all 0",
               mode, in_data_vld, pack_in(), busy, done, converged, epoch_cnt, err_cnt);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_and_converge();
    int nx;
    load_table(0);
    drive_training(2, 0, 0, 2, -1, -1, nx);
    n_total++;
    if (done !== 1'b1 || converged !== 1'b1 || epoch_cnt !== EW'(3) || err_cnt !== '0 || mode !== 1'b0)
      $display("FAIL and_converge: done=%b conv=%b epoch=%0d err=%0d mode=%b want 1 1 3 0 0",
               done, converged, epoch_cnt, err_cnt, mode);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (done !== 1'b1 || converged !== 1'b1)
      $display("FAIL done_hold: done=%b conv=%b want 1 1", done, converged);
    else n_pass++;
  endtask

  task automatic test_always_wrong();
    int nx;
    load_table(1);
    drive_training(1000, 1, 0, 1, -1, -1, nx);
    n_total++;
    if (done !== 1'b1 || converged !== 1'b0 || epoch_cnt !== EW'(4) || err_cnt !== CW'(4) || nx != 16)
      $display("FAIL always_wrong: done=%b conv=%b epoch=%0d err=%0d xfers=%0d want 1 0 4 4 16",
               done, converged, epoch_cnt, err_cnt, nx);
    else n_pass++;
  endtask

  task automatic test_stall();
    int nx;
    load_table(1);
    drive_training(0, 1, 5, 5, -1, -1, nx);
    n_total++;
    if (nx != N || converged !== 1'b1 || epoch_cnt !== EW'(1))
      $display("FAIL stall_run: xfers=%0d conv=%b epoch=%0d want %0d 1 1", nx, converged, epoch_cnt, N);
    else n_pass++;
  endtask

  task automatic test_ignored_inputs();
    int nx;
    load_table(1);
    drive_training(2, 1, 0, 2, 0, -1, nx);
    // Replaying shows the table was not modified by the dropped write.
    drive_training(0, 1, 0, 1, -1, -1, nx);
  endtask

  task automatic test_reset_mid();
    int nx;
    load_table(1);
    drive_training(1000, 1, 0, 1, -1, 1, nx);
    drive_training(0, 1, 0, 1, -1, -1, nx);
    n_total++;
    if (converged !== 1'b1 || epoch_cnt !== EW'(1) || nx != N)
      $display("FAIL after_abort: conv=%b epoch=%0d xfers=%0d want 1 1 %0d", converged, epoch_cnt, nx, N);
    else n_pass++;
  endtask

  task automatic test_random();
    int nx;
    for (int r = 0; r < 6; r++) begin
      load_table(1);
      drive_training($urandom_range(0, 5), 2, 0, 3, -1, -1, nx);
    end
  endtask

  initial begin
    rst = 1'b1; smp_wr_en = 1'b0; smp_wr_addr = '0; smp_wr_data = '0; smp_wr_exp = 1'b0;
    start = 1'b0; in_data_rdy = 1'b0; result_data = 1'b0; result_vld = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_and_converge();
    test_always_wrong();
    test_stall();
    test_ignored_inputs();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
